spike_inject_scheduler: RTL and testbench
=========================================

// Module: spike_inject_scheduler
// PURPOSE
//  Outbound counterpart of the neuron receive path. At the end of each time step it captures the
//  fired-neuron vector and schedules one packet per fired neuron, lowest index first.
//  Each packet is serialized onto the router injection port as packet_size/flit_size flits,
//  honouring the downstream full flag. Single clock domain: neuron_clk.
//  Packet layout matches the receive-side decode:
//    [x_address_length-1:0]                        = DEST_X
//    [x+y-1:x]                                     = DEST_Y
//    [x+y+NEURON_CNT_BIT_WIDTH-1:x+y]              = neuron index
//    all other bits                                = 0
// PARAMETERS
//  packet_size          32     packet width in bits; must be a multiple of flit_size
//  flit_size            4      flit width in bits; FLITS = packet_size/flit_size (8 at defaults)
//  x_address_length     8      destination X field width
//  y_address_length     8      destination Y field width
//  NEURON_CNT_BIT_WIDTH 2      neuron index width; NUM_NEURONS = 1<<NEURON_CNT_BIT_WIDTH
//  DEST_X               8'd1   destination X address placed in every packet
//  DEST_Y               8'd1   destination Y address placed in every packet
// PORTS
//  neuron_clk   in   1              clock
//  rst_n        in   1              asynchronous active-low reset
//  spike_valid  in   1              1-cycle pulse: spike_in holds this step's fired vector
//  spike_in     in   NUM_NEURONS    bit i = neuron i fired
//  full         in   1              downstream flit buffer full; no write while high
//  write_en     out  1              flit write strobe
//  data_out     out  flit_size      current flit
//  busy         out  1              high whenever state != IDLE
//  step_done    out  1              1-cycle pulse once all packets of the step have been sent
//  overflow     out  1              sticky; set when spike_valid arrives while busy
//  sent_count   out  16             packets fully sent since reset; wraps at 2^16
// BEHAVIOUR
//  Reset
//   - Async to IDLE. pending, flit_idx and packet register cleared.
//   - write_en, step_done, overflow, busy = 0; sent_count = 0; data_out = 0.
//   - Reset mid-packet abandons the packet; no further flits are written.
//  FSM
//   - IDLE: on spike_valid, pending <= spike_in; -> SCAN.
//   - SCAN: if pending == 0 -> DONE.
//           Else pick lowest set bit k, load packet for k, clear pending[k], flit_idx <= 0; -> SEND.
//   - SEND: write_en = !full (combinational); data_out = packet[flit_idx*flit_size +: flit_size].
//           Flits go least-significant first.
//           On a cycle with write_en: if flit_idx == FLITS-1 then sent_count++ and -> SCAN,
//           else flit_idx++.
//           With full high, hold flit_idx and data_out with write_en low; no timeout.
//   - DONE: step_done = 1 for exactly one cycle; -> IDLE.
//  Outputs
//   - write_en is only ever high in SEND.
//   - data_out is 0 outside SEND.
//  Latency (full low)
//   - spike_valid in cycle 0 -> SCAN in cycle 1 -> first write_en in cycle 2.
//   - Each packet takes FLITS cycles plus 1 SCAN bubble.
//   - n fired neurons -> step_done in cycle 2 + n*(FLITS+1).
//   - Zero fired neurons -> step_done in cycle 2.
//  Overflow
//   - spike_valid while busy (any state except IDLE, including DONE) is dropped.
//   - It sets overflow (cleared only by reset); the in-flight step is unaffected.
//  spike_valid in IDLE is accepted in the same cycle, including the cycle after DONE.
// TESTING
//  1. Reset, spike_in=4'b0000 valid -> no write_en; step_done in cycle 2; sent_count=0.
//  2. spike_in=4'b0100, full=0 -> 8 consecutive write_en from cycle 2.
//     Flits LS-first = 32'h0002_0101 -> 1,0,1,0,2,0,0,0; step_done cycle 11; sent_count=1.
//  3. spike_in=4'b1011 -> packets for neurons 0,1,3 in that order.
//     One bubble between packets; step_done cycle 29; sent_count=3.
//  4. full held high for 5 cycles during flit 3 of a packet -> write_en low those 5 cycles.
//     data_out stable at flit 3; resumes with flit 3 when full drops; no flit lost or duplicated.
//  5. Second spike_valid during SEND -> overflow=1 and stays 1.
//     The current step completes unchanged; the new vector is ignored.
//  6. rst_n low in mid-packet (flit 4) -> write_en=0 immediately; busy=0; sent_count=0.
//     After release, a new step sends complete packets.

Source files
------------

// File: rtl/spike_inject_scheduler.sv
// Spike injection scheduler: captures a time step's fired-neuron vector and serializes one packet
// per fired neuron (lowest index first) onto the router injection port as flits.
module spike_inject_scheduler #(
  parameter int unsigned packet_size          = 32,
  parameter int unsigned flit_size            = 4,
  parameter int unsigned x_address_length     = 8,
  parameter int unsigned y_address_length     = 8,
  parameter int unsigned NEURON_CNT_BIT_WIDTH = 2,
  parameter logic [x_address_length-1:0] DEST_X = x_address_length'(1),
  parameter logic [y_address_length-1:0] DEST_Y = y_address_length'(1),
  localparam int unsigned NUM_NEURONS = 1 << NEURON_CNT_BIT_WIDTH
) (
  input  logic                   neuron_clk,
  input  logic                   rst_n,
  input  logic                   spike_valid,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   full,
  output logic                   write_en,
  output logic [flit_size-1:0]   data_out,
  output logic                   busy,
  output logic                   step_done,
  output logic                   overflow,
  output logic [15:0]            sent_count
);

  localparam int unsigned FLITS    = packet_size / flit_size;
  localparam int unsigned FlitIdxW = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int unsigned NeuronW  = NEURON_CNT_BIT_WIDTH;
  localparam logic [FlitIdxW-1:0] LastFlit = FlitIdxW'(FLITS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StSend, StDone} state_e;

  state_e                  state_q, state_d;
  logic [NUM_NEURONS-1:0]  pending_q, pending_d;
  logic [FlitIdxW-1:0]     flit_idx_q, flit_idx_d;
  logic [packet_size-1:0]  packet_q, packet_d;
  logic [15:0]             sent_count_q, sent_count_d;
  logic                    overflow_q, overflow_d;

  logic [NeuronW-1:0]      pick_idx;
  logic [NUM_NEURONS-1:0]  pick_mask;
  logic [packet_size-1:0]  new_packet;
  logic [FLITS-1:0][flit_size-1:0] flits;

  assign flits = packet_q;

  // Descending scan so the last hit wins, leaving the lowest set index.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) pick_idx = NeuronW'(i);
    end
  end

  assign pick_mask = NUM_NEURONS'(1) << pick_idx;

  always_comb begin
    new_packet = '0;
    new_packet[x_address_length-1:0]                         = DEST_X;
    new_packet[x_address_length +: y_address_length]         = DEST_Y;
    new_packet[x_address_length + y_address_length +: NeuronW] = pick_idx;
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    flit_idx_d   = flit_idx_q;
    packet_d     = packet_q;
    sent_count_d = sent_count_q;
    overflow_d   = overflow_q | (spike_valid && (state_q != StIdle));
    write_en     = 1'b0;
    data_out     = '0;
    step_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (spike_valid) begin
          pending_d = spike_in;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (pending_q == '0) begin
          state_d = StDone;
        end else begin
          packet_d   = new_packet;
          pending_d  = pending_q & ~pick_mask;
          flit_idx_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        data_out = flits[flit_idx_q];
        write_en = !full;
        if (!full) begin
          if (flit_idx_q == LastFlit) begin
            sent_count_d = sent_count_q + 16'd1;
            state_d      = StScan;
          end else begin
            flit_idx_d = flit_idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        step_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      flit_idx_q   <= '0;
      packet_q     <= '0;
      sent_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      flit_idx_q   <= flit_idx_d;
      packet_q     <= packet_d;
      sent_count_q <= sent_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign overflow   = overflow_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_spike_inject_scheduler.sv
// Self-checking bench for spike_inject_scheduler: randomized steps compared against a
// packet-level model of the flit stream, step timing and counters.
module tb_spike_inject_scheduler;

  localparam int NN      = 4;
  localparam int NFLITS  = 8;
  localparam int HistLen = 400;
  localparam logic [7:0] DX = 8'd1;
  localparam logic [7:0] DY = 8'd1;

  logic          neuron_clk;
  logic          rst_n;
  logic          spike_valid;
  logic [NN-1:0] spike_in;
  logic          full;
  logic          write_en;
  logic [3:0]    data_out;
  logic          busy;
  logic          step_done;
  logic          overflow;
  logic [15:0]   sent_count;

  spike_inject_scheduler #(
    .packet_size(32), .flit_size(4), .x_address_length(8), .y_address_length(8),
    .NEURON_CNT_BIT_WIDTH(2), .DEST_X(DX), .DEST_Y(DY)
  ) dut (
    .neuron_clk (neuron_clk),
    .rst_n      (rst_n),
    .spike_valid(spike_valid),
    .spike_in   (spike_in),
    .full       (full),
    .write_en   (write_en),
    .data_out   (data_out),
    .busy       (busy),
    .step_done  (step_done),
    .overflow   (overflow),
    .sent_count (sent_count)
  );

  initial neuron_clk = 1'b0;
  always #5 neuron_clk = ~neuron_clk;

  int total = 0;
  int bad   = 0;
  int exp_sent;
  int done_cyc, first_wen, stall_bad;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];
  logic       wen_hist[HistLen];
  logic [3:0] dout_hist[HistLen];
  logic       busy_hist[HistLen];

  // Model: packet = neuron index at bit 16, DEST_Y at bit 8, DEST_X at bit 0.
  function automatic logic [31:0] pkt_for(input int k);
    return 32'(k) * 32'h0001_0000 + 32'(DY) * 32'h0000_0100 + 32'(DX);
  endfunction

  function automatic void build_expected(input logic [NN-1:0] vec);
    logic [31:0] p;
    exp_q.delete();
    for (int k = 0; k < NN; k++) begin
      if (vec[k]) begin
        p = pkt_for(k);
        for (int j = 0; j < NFLITS; j++) exp_q.push_back(4'((p >> (4 * j)) & 32'hF));
      end
    end
  endfunction

  function automatic int flit_errs();
    int e = 0;
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    e = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                      : exp_q.size() - got_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // Runs one time step starting in the next cycle (cycle 0 = spike_valid cycle).
  task automatic run_step(input logic [NN-1:0] vec, input int pct, input int fs, input int fl,
                          input int inj_c, input logic [NN-1:0] inj_vec);
    got_q.delete();
    done_cyc = -1; first_wen = -1; stall_bad = 0;
    for (int i = 0; i < HistLen; i++) begin
      wen_hist[i] = 1'b0; dout_hist[i] = '0; busy_hist[i] = 1'b0;
    end
    @(posedge neuron_clk); #1;
    spike_valid = 1'b1; spike_in = vec; full = 1'b0;
    for (int c = 0; c < HistLen; c++) begin
      @(negedge neuron_clk);
      wen_hist[c] = write_en; dout_hist[c] = data_out; busy_hist[c] = busy;
      if (write_en === 1'b1) begin
        got_q.push_back(data_out);
        if (first_wen < 0) first_wen = c;
        if (full) stall_bad++;
      end
      if (step_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(posedge neuron_clk); #1;
      spike_valid = (c + 1 == inj_c);
      if (c + 1 == inj_c) spike_in = inj_vec;
      full = ((c + 1 >= fs) && (c + 1 < fs + fl)) || (int'($urandom_range(99)) < pct);
    end
    full = 1'b0; spike_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spike_valid = 1'b0; spike_in = '0; full = 1'b0;
    repeat (3) @(posedge neuron_clk);
    @(negedge neuron_clk);
    total++; if (write_en !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", write_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (step_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", step_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", sent_count); end
    total++; if (data_out !== 4'd0) begin bad++; $display("FAIL reset_dout: got %0d want 0", data_out); end
    rst_n = 1'b1;
    exp_sent = 0;
  endtask

  task automatic test_zero_step();
    run_step(4'b0000, 0, 0, 0, -1, '0);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL zero_flits: got %0d want 0", got_q.size()); end
    total++; if (done_cyc != 2) begin bad++; $display("FAIL zero_done_cyc: got %0d want 2", done_cyc); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL zero_cnt: got %0d want %0d", sent_count, exp_sent); end
    @(posedge neuron_clk); #1;
    @(negedge neuron_clk);
    total++; if (step_done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", step_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int n = 0;
    build_expected(4'b0100);
    run_step(4'b0100, 0, 0, 0, -1, '0);
    exp_sent += 1;
    for (int c = 2; c <= 9; c++) if (wen_hist[c]) n++;
    total++; if (flit_errs() != 0) begin bad++; $display("FAIL single_flits: got %0d errs want 0", flit_errs()); end
    total++; if (first_wen != 2) begin bad++; $display("FAIL single_first: got %0d want 2", first_wen); end
    total++; if (n != 8) begin bad++; $display("FAIL single_consec: got %0d want 8", n); end
    total++; if (done_cyc != 11) begin bad++; $display("FAIL single_done_cyc: got %0d want 11", done_cyc); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL single_cnt: got %0d want %0d", sent_count, exp_sent); end
  endtask

  task automatic test_multi();
    build_expected(4'b1011);
    run_step(4'b1011, 0, 0, 0, -1, '0);
    exp_sent += 3;
    total++; if (flit_errs() != 0) begin bad++; $display("FAIL multi_flits: got %0d errs want 0", flit_errs()); end
    total++; if (wen_hist[10] !== 1'b0) begin bad++; $display("FAIL multi_bubble: got %b want 0", wen_hist[10]); end
    total++; if (busy_hist[1] !== 1'b1) begin bad++; $display("FAIL multi_busy: got %b want 1", busy_hist[1]); end
    total++; if (done_cyc != 29) begin bad++; $display("FAIL multi_done_cyc: got %0d want 29", done_cyc); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL multi_cnt: got %0d want %0d", sent_count, exp_sent); end
  endtask

  task automatic test_backpressure();
    int wen_hi = 0;
    int dout_bad = 0;
    build_expected(4'b0001);
    run_step(4'b0001, 0, 5, 5, -1, '0);
    exp_sent += 1;
    for (int c = 5; c <= 9; c++) begin
      if (wen_hist[c]) wen_hi++;
      if (dout_hist[c] !== exp_q[3]) dout_bad++;
    end
    total++; if (wen_hi != 0) begin bad++; $display("FAIL bp_wen_low: got %0d high want 0", wen_hi); end
    total++; if (dout_bad != 0) begin bad++; $display("FAIL bp_dout_hold: got %0d bad want 0", dout_bad); end
    total++; if (flit_errs() != 0) begin bad++; $display("FAIL bp_flits: got %0d errs want 0", flit_errs()); end
    total++; if (done_cyc != 16) begin bad++; $display("FAIL bp_done_cyc: got %0d want 16", done_cyc); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_wen_full: got %0d want 0", stall_bad); end
  endtask

  task automatic test_overflow();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", overflow); end
    build_expected(4'b0110);
    run_step(4'b0110, 0, 0, 0, 4, 4'b1000);
    exp_sent += 2;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    total++; if (flit_errs() != 0) begin bad++; $display("FAIL ovf_flits: got %0d errs want 0", flit_errs()); end
    total++; if (done_cyc != 20) begin bad++; $display("FAIL ovf_done_cyc: got %0d want 20", done_cyc); end
    build_expected(4'b0001);
    run_step(4'b0001, 0, 0, 0, -1, '0);
    exp_sent += 1;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    total++; if (flit_errs() != 0) begin bad++; $display("FAIL ovf_next_flits: got %0d errs want 0", flit_errs()); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL ovf_cnt: got %0d want %0d", sent_count, exp_sent); end
  endtask

  task automatic test_reset_mid();
    build_expected(4'b0001);
    @(posedge neuron_clk); #1;
    spike_valid = 1'b1; spike_in = 4'b0001;
    repeat (6) begin
      @(posedge neuron_clk); #1;
      spike_valid = 1'b0;
    end
    @(negedge neuron_clk);
    total++; if (write_en !== 1'b1 || data_out !== exp_q[4]) begin
      bad++; $display("FAIL rstmid_flit4: got wen=%b dout=%0d want wen=1 dout=%0d", write_en, data_out, exp_q[4]);
    end
    #1 rst_n = 1'b0;
    #1;
    total++; if (write_en !== 1'b0) begin bad++; $display("FAIL rstmid_wen: got %b want 0", write_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", sent_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    repeat (2) @(posedge neuron_clk);
    @(negedge neuron_clk);
    rst_n = 1'b1;
    exp_sent = 0;
    build_expected(4'b1001);
    run_step(4'b1001, 0, 0, 0, -1, '0);
    exp_sent += 2;
    total++; if (flit_errs() != 0) begin bad++; $display("FAIL rstmid_after_flits: got %0d errs want 0", flit_errs()); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL rstmid_after_cnt: got %0d want %0d", sent_count, exp_sent); end
  endtask

  // Back-to-back steps: each new step starts in the cycle right after step_done.
  task automatic test_random();
    logic [NN-1:0] vec;
    int pct;
    int n;
    for (int it = 0; it < 24; it++) begin
      vec = NN'($urandom_range(15));
      pct = (it % 2 == 1) ? int'($urandom_range(40)) : 0;
      n   = $countones(vec);
      build_expected(vec);
      run_step(vec, pct, 0, 0, -1, '0);
      exp_sent += n;
      total++; if (flit_errs() != 0) begin bad++; $display("FAIL rand_flits[%0d]: got %0d errs want 0", it, flit_errs()); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL rand_wen_full[%0d]: got %0d want 0", it, stall_bad); end
      total++; if (done_cyc < 0) begin bad++; $display("FAIL rand_timeout[%0d]: got %0d want done", it, done_cyc); end
      if (pct == 0) begin
        total++; if (done_cyc != 2 + n * (NFLITS + 1)) begin
          bad++; $display("FAIL rand_done_cyc[%0d]: got %0d want %0d", it, done_cyc, 2 + n * (NFLITS + 1));
        end
      end
      total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", it, sent_count, exp_sent); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_step();
    test_single();
    test_multi();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
